// File: rtl/vga_timing_pkg.sv
// Shared constants and state encoding for the VGA sync timing monitor.
// Values describe 640x480@60 as produced by display_controller on a
// 100 MHz system clock (4 system clocks per pixel clock).
// No ports: package only.
package vga_timing_pkg;

   localparam int unsigned CLK_PER_PIXEL = 4;
   localparam int unsigned H_TOTAL       = 800;
   localparam int unsigned H_SYNC        = 96;
   localparam int unsigned V_TOTAL       = 525;
   localparam int unsigned V_SYNC        = 2;
   localparam int unsigned LOCK_FRAMES   = 2;

   // Expected measurements in system clocks for the default mode.
   localparam int unsigned LINE_CLKS_EXP  = H_TOTAL * CLK_PER_PIXEL;          // 3200
   localparam int unsigned HSYNC_CLKS_EXP = H_SYNC * CLK_PER_PIXEL;           // 384
   localparam int unsigned VSYNC_CLKS_EXP = V_SYNC * H_TOTAL * CLK_PER_PIXEL; // 6400

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register for one active-low sync input.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset
//   sync_i  in  asynchronous sync pin
//   level_o out synchronized level, aligned with the edge pulses
//   fall_o  out one-clock pulse, 3 clocks after a pin falling edge
//   rise_o  out one-clock pulse, 3 clocks after a pin rising edge
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sync_i,
   output logic level_o,
   output logic fall_o,
   output logic rise_o
);

   logic [1:0] sync_q;
   logic       level_q;
   logic [2:0] fill_q;
   logic       fall_q;
   logic       rise_q;

   // fill_q marks when level_q holds a real sample again after reset, so
   // the reset value of the pipeline never produces a fake edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fill_q  <= 3'b000;
         fall_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], sync_i};
         level_q <= sync_q[1];
         fill_q  <= {fill_q[1:0], 1'b1};
         fall_q  <= fill_q[2] &  level_q & ~sync_q[1];
         rise_q  <= fill_q[2] & ~level_q &  sync_q[1];
      end
   end

   assign level_o = level_q;
   assign fall_o  = fall_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/vga_timing_checker.sv
// Receive-side monitor for the VGA hSync/vSync pair. Measures line period,
// hSync and vSync low widths and lines per frame, flags deviations from
// the configured mode and declares lock after LOCK_FRAMES clean frames.
// Ports:
//   Clk, Reset   system clock, synchronous active-high reset
//   hSync, vSync active-low sync inputs (asynchronous to Clk)
//   locked       timing verified
//   line_clks    last line period (clocks)
//   hsync_clks   last hSync low width (clocks)
//   vsync_clks   last vSync low width (clocks)
//   frame_lines  lines in the last full frame
//   err_count    timing errors, saturating at 255
//   frame_count  completed frames, wrapping
//   dbg_state    current FSM state
module vga_timing_checker #(
   parameter int unsigned CLK_PER_PIXEL = vga_timing_pkg::CLK_PER_PIXEL,
   parameter int unsigned H_TOTAL       = vga_timing_pkg::H_TOTAL,
   parameter int unsigned H_SYNC        = vga_timing_pkg::H_SYNC,
   parameter int unsigned V_TOTAL       = vga_timing_pkg::V_TOTAL,
   parameter int unsigned V_SYNC        = vga_timing_pkg::V_SYNC,
   parameter int unsigned LOCK_FRAMES   = vga_timing_pkg::LOCK_FRAMES
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   hSync,
   input  logic                   vSync,
   output logic                   locked,
   output logic [11:0]            line_clks,
   output logic [11:0]            hsync_clks,
   output logic [13:0]            vsync_clks,
   output logic [9:0]             frame_lines,
   output logic [7:0]             err_count,
   output logic [15:0]            frame_count,
   output vga_timing_pkg::state_t dbg_state
);
   import vga_timing_pkg::*;

   localparam logic [11:0] EXP_LINE_CLKS  = 12'(H_TOTAL * CLK_PER_PIXEL);
   localparam logic [11:0] EXP_HSYNC_CLKS = 12'(H_SYNC * CLK_PER_PIXEL);
   localparam logic [13:0] EXP_VSYNC_CLKS = 14'(V_SYNC * H_TOTAL * CLK_PER_PIXEL);
   localparam logic [12:0] TIMEOUT_CLKS   = 13'(2 * H_TOTAL * CLK_PER_PIXEL);
   localparam logic [9:0]  EXP_LINES      = 10'(V_TOTAL);
   localparam logic [7:0]  LOCK_GOOD      = 8'(LOCK_FRAMES);

   logic h_level, h_fall, h_rise;
   logic v_level, v_fall, v_rise;

   sync_edge_detect u_hsync (
      .clk_i(Clk), .rst_i(Reset), .sync_i(hSync),
      .level_o(h_level), .fall_o(h_fall), .rise_o(h_rise)
   );

   sync_edge_detect u_vsync (
      .clk_i(Clk), .rst_i(Reset), .sync_i(vSync),
      .level_o(v_level), .fall_o(v_fall), .rise_o(v_rise)
   );

   state_t      state_q, state_d;
   logic [7:0]  good_cnt_q, good_cnt_d;
   logic        frame_bad_q, frame_bad_d;
   logic [12:0] hper_cnt_q, hper_cnt_d;
   logic [11:0] hlow_cnt_q, hlow_cnt_d;
   logic [13:0] vlow_cnt_q, vlow_cnt_d;
   logic [9:0]  line_cnt_q, line_cnt_d;
   logic [11:0] line_clks_q, line_clks_d;
   logic [11:0] hsync_clks_q, hsync_clks_d;
   logic [13:0] vsync_clks_q, vsync_clks_d;
   logic [9:0]  frame_lines_q, frame_lines_d;
   logic [7:0]  err_count_q, err_count_d;
   logic [15:0] frame_count_q, frame_count_d;

   logic [11:0] line_meas;
   logic [9:0]  frame_meas;
   logic [7:0]  good_inc;
   logic        active, line_err, vsync_err, lines_err, timeout, frame_bad_now;

   always_comb begin
      // Measurements as they would be latched this cycle.
      line_meas  = (hper_cnt_q >= 13'd4095) ? 12'hFFF : hper_cnt_q[11:0] + 12'd1;
      // A coincident hfall belongs to the frame that vfall is closing.
      frame_meas = (line_cnt_q == 10'h3FF) ? 10'h3FF : line_cnt_q + {9'd0, h_fall};
      good_inc   = good_cnt_q + 8'd1;

      active        = (state_q != IDLE);
      line_err      = active && ((h_fall && line_meas != EXP_LINE_CLKS) ||
                                 (h_rise && hlow_cnt_q != EXP_HSYNC_CLKS));
      vsync_err     = active && v_rise && (vlow_cnt_q != EXP_VSYNC_CLKS);
      lines_err     = active && v_fall && (frame_meas != EXP_LINES);
      timeout       = active && !h_fall && (hper_cnt_q == TIMEOUT_CLKS);
      frame_bad_now = frame_bad_q | line_err | vsync_err | lines_err;

      // Counters
      hper_cnt_d = h_fall ? 13'd0 : ((hper_cnt_q == 13'h1FFF) ? hper_cnt_q : hper_cnt_q + 13'd1);
      hlow_cnt_d = hlow_cnt_q;
      if (h_rise)
         hlow_cnt_d = 12'd0;
      else if (!h_level && hlow_cnt_q != 12'hFFF)
         hlow_cnt_d = hlow_cnt_q + 12'd1;
      vlow_cnt_d = vlow_cnt_q;
      if (v_rise)
         vlow_cnt_d = 14'd0;
      else if (!v_level && vlow_cnt_q != 14'h3FFF)
         vlow_cnt_d = vlow_cnt_q + 14'd1;
      line_cnt_d = line_cnt_q;
      if (v_fall)
         line_cnt_d = 10'd0;
      else if (h_fall && line_cnt_q != 10'h3FF)
         line_cnt_d = line_cnt_q + 10'd1;

      // Measured outputs
      line_clks_d   = h_fall ? line_meas  : line_clks_q;
      hsync_clks_d  = h_rise ? hlow_cnt_q : hsync_clks_q;
      vsync_clks_d  = v_rise ? vlow_cnt_q : vsync_clks_q;
      frame_lines_d = v_fall ? frame_meas : frame_lines_q;

      // Frame evaluation and lock FSM
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (v_fall) begin
               state_d    = CHECK;
               good_cnt_d = 8'd0;
            end
         end
         CHECK: begin
            if (v_fall) begin
               if (frame_bad_now) begin
                  good_cnt_d = 8'd0;
               end else begin
                  good_cnt_d = good_inc;
                  if (good_inc >= LOCK_GOOD) state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (line_err || (v_fall && frame_bad_now)) begin
               state_d    = CHECK;
               good_cnt_d = 8'd0;
            end
         end
         default: begin
            state_d    = IDLE;
            good_cnt_d = 8'd0;
         end
      endcase
      if (timeout) begin
         state_d    = IDLE;
         good_cnt_d = 8'd0;
      end

      // Sticky per-frame flag, cleared once vfall has evaluated it.
      frame_bad_d = frame_bad_q;
      if (v_fall || timeout)
         frame_bad_d = 1'b0;
      else if (line_err || vsync_err)
         frame_bad_d = 1'b1;

      err_count_d = err_count_q;
      if ((line_err || vsync_err || lines_err || timeout) && err_count_q != 8'hFF)
         err_count_d = err_count_q + 8'd1;

      // The vfall that opens the first checked frame counts as well.
      frame_count_d = frame_count_q;
      if (v_fall && state_d != IDLE)
         frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         good_cnt_q    <= 8'd0;
         frame_bad_q   <= 1'b0;
         hper_cnt_q    <= 13'd0;
         hlow_cnt_q    <= 12'd0;
         vlow_cnt_q    <= 14'd0;
         line_cnt_q    <= 10'd0;
         line_clks_q   <= 12'd0;
         hsync_clks_q  <= 12'd0;
         vsync_clks_q  <= 14'd0;
         frame_lines_q <= 10'd0;
         err_count_q   <= 8'd0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         frame_bad_q   <= frame_bad_d;
         hper_cnt_q    <= hper_cnt_d;
         hlow_cnt_q    <= hlow_cnt_d;
         vlow_cnt_q    <= vlow_cnt_d;
         line_cnt_q    <= line_cnt_d;
         line_clks_q   <= line_clks_d;
         hsync_clks_q  <= hsync_clks_d;
         vsync_clks_q  <= vsync_clks_d;
         frame_lines_q <= frame_lines_d;
         err_count_q   <= err_count_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign locked      = (state_q == LOCKED);
   assign line_clks   = line_clks_q;
   assign hsync_clks  = hsync_clks_q;
   assign vsync_clks  = vsync_clks_q;
   assign frame_lines = frame_lines_q;
   assign err_count   = err_count_q;
   assign frame_count = frame_count_q;
   assign dbg_state   = state_q;

endmodule
